// File: rtl/circuit2_sched_pkg.sv
// Shared types and constants for the circuit2 multi-cycle scheduler.
package circuit2_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_D = 3'd1,
    ADD_E = 3'd2,
    SUB_F = 3'd3,
    CMP   = 3'd4,
    SHL_X = 3'd5,
    SHR_Z = 3'd6,
    DONE  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_CMP = 2'd2
  } alu_op_t;

  typedef enum logic {
    SH_L  = 1'b0,
    SH_RA = 1'b1
  } shf_op_t;

  // Start-to-start period of a job when start is held high: seven busy states plus one IDLE cycle.
  localparam int LATENCY = 8;

endpackage

// File: rtl/circuit2_sched_if.sv
// Operand source / result consumer bundle for circuit2_sched.
interface circuit2_sched_if #(
  parameter int DATAWIDTH = 32
);
  logic                 start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] x;
  logic [DATAWIDTH-1:0] z;
  logic [DATAWIDTH-1:0] f;

  modport master (output start, a, b, c, input busy, done, x, z, f);
  modport slave  (input start, a, b, c, output busy, done, x, z, f);
endinterface

// File: rtl/circuit2_sched_shared_alu.sv
// Single shared signed add/sub/compare unit; purely combinational.
module shared_alu
  import circuit2_sched_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  alu_op_t              op,
  input  logic [DATAWIDTH-1:0] p,
  input  logic [DATAWIDTH-1:0] q,
  output logic [DATAWIDTH-1:0] res,
  output logic                 lt,
  output logic                 eq
);

  // Add or subtract with natural wrap; flags are always a signed compare of p and q.
  always_comb begin
    case (op)
      OP_SUB:  res = p - q;
      default: res = p + q;
    endcase
    lt = $signed(p) < $signed(q);
    eq = (p == q);
  end

endmodule

// File: rtl/circuit2_sched.sv
// circuit2 dataflow scheduled over one shared ALU and one shared shifter.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// ADD_D | d = a + b
// ADD_E | e = a + c
// SUB_F | f = a - b (written to output)
// CMP   | lt/eq flags from signed compare of d and e
// SHL_X | x = d << lt
// SHR_Z | z = d >>> eq
// DONE  | done pulse, results stable
module circuit2_sched
  import circuit2_sched_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  circuit2_sched_if.slave bus
);

  state_t               state;
  logic [DATAWIDTH-1:0] ra, rb, rc;
  logic [DATAWIDTH-1:0] d, e;
  logic                 dlt, deq;
  logic [DATAWIDTH-1:0] x_q, z_q, f_q;
  logic                 busy_q, done_q;

  alu_op_t              alu_op;
  logic [DATAWIDTH-1:0] alu_p, alu_q, alu_res;
  logic                 alu_lt, alu_eq;
  shf_op_t              sh_op;
  logic [DATAWIDTH-1:0] sh_out;

  shared_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
    .op  (alu_op),
    .p   (alu_p),
    .q   (alu_q),
    .res (alu_res),
    .lt  (alu_lt),
    .eq  (alu_eq)
  );

  // Per-state operand steering into the shared ALU.
  always_comb begin
    alu_op = OP_ADD;
    alu_p  = ra;
    alu_q  = rb;
    case (state)
      ADD_E: alu_q = rc;
      SUB_F: alu_op = OP_SUB;
      CMP: begin
        alu_op = OP_CMP;
        alu_p  = d;
        alu_q  = e;
      end
      default: ;
    endcase
  end

  // Shared shifter; g and h both alias d, so d feeds it directly.
  always_comb begin
    sh_op = (state == SHR_Z) ? SH_RA : SH_L;
    case (sh_op)
      SH_RA:   sh_out = $signed(d) >>> deq;
      default: sh_out = d << dlt;
    endcase
  end

  // Controller FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rc     <= '0;
      d      <= '0;
      e      <= '0;
      dlt    <= 1'b0;
      deq    <= 1'b0;
      x_q    <= '0;
      z_q    <= '0;
      f_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra     <= bus.a;
            rb     <= bus.b;
            rc     <= bus.c;
            busy_q <= 1'b1;
            state  <= ADD_D;
          end
        end
        ADD_D: begin
          d     <= alu_res;
          state <= ADD_E;
        end
        ADD_E: begin
          e     <= alu_res;
          state <= SUB_F;
        end
        SUB_F: begin
          f_q   <= alu_res;
          state <= CMP;
        end
        CMP: begin
          dlt   <= alu_lt;
          deq   <= alu_eq;
          state <= SHL_X;
        end
        SHL_X: begin
          x_q   <= sh_out;
          state <= SHR_Z;
        end
        SHR_Z: begin
          z_q    <= sh_out;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.x    = x_q;
  assign bus.z    = z_q;
  assign bus.f    = f_q;

endmodule

// File: tb/tb_circuit2_sched.sv
// Scoreboard bench for circuit2_sched.
module tb_circuit2_sched;
  import circuit2_sched_pkg::*;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] z;
    logic [31:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  circuit2_sched_if #(.DATAWIDTH(32)) bus ();

  circuit2_sched #(.DATAWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_exp;
  int   nvec      = 0;
  int   nerr      = 0;
  int   cyc       = 0;
  int   done_cnt  = 0;
  int   last_done = -100;
  int   done_gap  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic signed [31:0] a, b, c);
    logic signed [31:0] dd, ee;
    exp_t m;
    dd  = a + b;
    ee  = a + c;
    m.f = a - b;
    m.x = (dd < ee) ? (dd << 1) : dd;
    m.z = (dd == ee) ? (dd >>> 1) : dd;
    return m;
  endfunction

  // Cycle counter used to measure the spacing of done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      done_gap  = cyc - last_done;
      last_done = cyc;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexp_done", {31'b0, bus.done}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("x", bus.x, mon_exp.x);
        chk("z", bus.z, mon_exp.z);
        chk("f", bus.f, mon_exp.f);
      end
    end
  end

  // One job with latency/busy checks, operand scrambling and an ignored start while busy.
  task automatic run_job(input logic [31:0] a, b, c);
    int n;
    int nbusy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    sb.push_back(model(a, b, c));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.c = $urandom;
    n = 1;
    nbusy = int'(bus.busy);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
      nbusy += int'(bus.busy);
      bus.start = (n == 3);
    end
    bus.start = 1'b0;
    // Edges after the accepting edge until done is visible; busy spans ADD_D..DONE.
    chk("latency", n, LATENCY - 1);
    chk("busy_cycles", nbusy, LATENCY - 1);
    @(negedge clk);
    chk("busy_idle", {31'b0, bus.busy}, 32'd0);
    chk("done_single", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_x", bus.x, 32'd0);
    chk("rst_z", bus.z, 32'd0);
    chk("rst_f", bus.f, 32'd0);
    rst = 1'b1;

    run_job(32'd5, 32'd3, 32'd1);
    run_job(32'd1, 32'd2, 32'd4);
    run_job(-32'sd7, 32'd0, 32'd0);
    run_job(32'h7FFF_FFFF, 32'd1, 32'd2);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_job(ra, rb, (i % 2 == 0) ? rb : 32'($urandom));
    end

    // Reset during CMP aborts the job and clears outputs immediately.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd10;
    bus.b = 32'd3;
    bus.c = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_f", bus.f, 32'd7);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_x", bus.x, 32'd0);
    chk("mid_rst_z", bus.z, 32'd0);
    chk("mid_rst_f", bus.f, 32'd0);
    d0 = done_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", {31'b0, bus.done}, 32'd0);
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_job(32'd5, 32'd3, 32'd1);

    // start held high: accepts on the first edge and again on the first IDLE cycle after DONE.
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd1;
    bus.b = 32'd2;
    bus.c = 32'd4;
    sb.push_back(model(32'd1, 32'd2, 32'd4));
    @(negedge clk);
    bus.a = 32'hFFFF_FFF9;
    bus.b = 32'd0;
    bus.c = 32'd0;
    sb.push_back(model(32'hFFFF_FFF9, 32'd0, 32'd0));
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_jobs", done_cnt - d0, 2);
    chk("b2b_gap", done_gap, LATENCY);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
